// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared states, field encodings, BCD slices and limits for the clock set controller.
package clock_ctrl_pkg;
    typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, LOAD} state_e;
    localparam logic [1:0] FS_NONE = 2'd0;
    localparam logic [1:0] FS_HR = 2'd1;
    localparam logic [1:0] FS_MIN = 2'd2;
    localparam logic [1:0] FS_SEC = 2'd3;
    localparam int HR_HI = 23;
    localparam int HR_LO = 16;
    localparam int MIN_HI = 15;
    localparam int MIN_LO = 8;
    localparam int SEC_HI = 7;
    localparam int SEC_LO = 0;
    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX = 8'h59;
    function automatic logic [1:0] field_of(input state_e s);
        return s == SET_HR ? FS_HR : s == SET_MIN ? FS_MIN : s == SET_SEC ? FS_SEC : FS_NONE;
    endfunction
endpackage

// File: rtl/clock_set_controller_if.sv
// clock_set_controller_if: front-panel buttons and counter-chain signals of the clock set controller.
interface clock_set_controller_if;
    logic        Mode_btn;
    logic        Inc_btn;
    logic        Cancel_btn;
    logic [23:0] Time_cur;
    logic        Sec_tick;
    logic        Set_time;
    logic [23:0] Time_in;
    logic [1:0]  Field_sel;
    modport master (
        output Mode_btn, Inc_btn, Cancel_btn, Time_cur,
        input  Sec_tick, Set_time, Time_in, Field_sel
    );
    modport slave (
        input  Mode_btn, Inc_btn, Cancel_btn, Time_cur,
        output Sec_tick, Set_time, Time_in, Field_sel
    );
endinterface

// File: rtl/bcd2_inc.sv
// bcd2_inc: two-digit BCD increment, wrapping max to 00 and mapping invalid values to 00.
module bcd2_inc (
    input  logic [7:0] val_i,
    input  logic [7:0] max_i,
    output logic [7:0] val_o
);
    logic valid;
    always_comb begin
        valid = val_i[7:4] <= 4'd9 && val_i[3:0] <= 4'd9 && val_i <= max_i;
        val_o = (!valid || val_i == max_i) ? 8'h00 :
                val_i[3:0] == 4'd9 ? {val_i[7:4] + 4'd1, 4'h0} : val_i + 8'd1;
    end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: one-second tick prescaler plus button-driven set-time FSM
// that edits a captured copy of the time and loads it back into the counter chain.
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input logic CLK,
    input logic Reset_n,
    clock_set_controller_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   edit_q, edit_d;
    logic          tick_q, tick_d;
    logic          load_q, load_d;
    logic [1:0]    fsel_q;
    logic [7:0]    hr_nxt, min_nxt;
    logic          inc;

    bcd2_inc u_hr (.val_i(edit_q[HR_HI:HR_LO]), .max_i(HR_MAX), .val_o(hr_nxt));
    bcd2_inc u_min (.val_i(edit_q[MIN_HI:MIN_LO]), .max_i(MIN_MAX), .val_o(min_nxt));

    always_comb begin
        // Cancel beats Mode beats Inc; a losing pulse is simply dropped.
        inc = bus.Inc_btn && !bus.Mode_btn && !bus.Cancel_btn;
        state_d = state_q;
        edit_d = edit_q;
        case (state_q)
            RUN:     state_d = bus.Mode_btn ? SET_HR : RUN;
            SET_HR:  state_d = bus.Cancel_btn ? RUN : bus.Mode_btn ? SET_MIN : SET_HR;
            SET_MIN: state_d = bus.Cancel_btn ? RUN : bus.Mode_btn ? SET_SEC : SET_MIN;
            SET_SEC: state_d = bus.Cancel_btn ? RUN : bus.Mode_btn ? LOAD : SET_SEC;
            default: state_d = RUN;
        endcase
        if (state_q == RUN && bus.Mode_btn)
            edit_d = bus.Time_cur;
        if (state_q == SET_HR && inc)
            edit_d[HR_HI:HR_LO] = hr_nxt;
        if (state_q == SET_MIN && inc)
            edit_d[MIN_HI:MIN_LO] = min_nxt;
        if (state_q == SET_SEC && inc)
            edit_d[SEC_HI:SEC_LO] = 8'h00;
        // Count only while staying in RUN so every RUN entry starts a full second.
        presc_d = (state_q == RUN && state_d == RUN && presc_q != P_MAX) ? presc_q + 1'b1 : '0;
        tick_d = state_d == RUN && presc_d == P_MAX;
        load_d = state_d == LOAD;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q <= RUN;
            presc_q <= '0;
            edit_q <= '0;
            tick_q <= 1'b0;
            load_q <= 1'b0;
            fsel_q <= FS_NONE;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            edit_q <= edit_d;
            tick_q <= tick_d;
            load_q <= load_d;
            fsel_q <= field_of(state_d);
        end
    end

    assign bus.Sec_tick = tick_q;
    assign bus.Set_time = load_q;
    assign bus.Time_in = edit_q;
    assign bus.Field_sel = fsel_q;
endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Sequencer for the 24-hour BCD clock counter chain. Generates the one-second enable tick in normal running and implements a button-driven set-time state machine. The state machine captures the current time, lets the user step hours, minutes and seconds, then issues a one-cycle load (`Set_time` / `Time_in`) to the counter chain. Sits between the debounced front-panel buttons and the clock counter chain's `LD`/`D`/`EN` inputs.

## Interface
- `TICK_DIV`, default 50_000_000: CLK cycles per one-second tick; legal range ≥ 1.
- `CLK`  in  1  system clock; all state updates on rising edge.
- `Reset_n`  in  1  synchronous, active-low reset.
- `Mode_btn`  in  1  single-cycle, already-synchronised pulse; advances field / commits.
- `Inc_btn`  in  1  single-cycle pulse; steps the selected field.
- `Cancel_btn`  in  1  single-cycle pulse; abandons editing.
- `Time_cur`  in  24  current BCD time from counter chain: [23:20] hr tens, [19:16] hr units, [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
- `Sec_tick`  out  1  one-cycle counting enable to the seconds counter.
- `Set_time`  out  1  one-cycle load strobe to all counters.
- `Time_in`  out  24  edit register, same BCD layout as `Time_cur`.
- `Field_sel`  out  2  field being edited: 0 none, 1 hours, 2 minutes, 3 seconds (display blink).

## Operation
- States: RUN, SET_HR, SET_MIN, SET_SEC, LOAD.
- **Reset (`Reset_n`=0 at an edge):**
  - State → RUN; prescaler → 0; edit register → 0x000000.
  - Outputs: `Sec_tick`=0, `Set_time`=0, `Time_in`=0, `Field_sel`=0.
  - Applies in any state, including mid-edit or during LOAD; no load strobe is issued.
- **RUN:**
  - Prescaler counts 0..TICK_DIV-1 and wraps; `Sec_tick`=1 for the cycle in which the count equals TICK_DIV-1.
  - `Mode_btn`: capture `Time_cur` into the edit register, go to SET_HR.
  - `Inc_btn` and `Cancel_btn` are ignored.
- **SET_HR:**
  - `Inc_btn` steps hours by 1 BCD: units 9 → 0 with tens +1; 23 → 00.
- **SET_MIN:**
  - `Inc_btn` steps minutes: units 9 → 0 with tens +1; 59 → 00.
- **SET_SEC:**
  - `Inc_btn` clears seconds to 00.
- **Mode sequence:** `Mode_btn` advances SET_HR → SET_MIN → SET_SEC → LOAD.
- **Cancel:** `Cancel_btn` in any SET_* state → RUN with no load; the edit register keeps its value.
- **LOAD:** `Set_time`=1 for exactly one cycle with `Time_in` = edit register; next state is RUN unconditionally. All buttons are ignored in LOAD.
- **Prescaler outside RUN:** held at 0 in every non-RUN state, and `Sec_tick`=0.
- **Simultaneous pulses:** priority Cancel > Mode > Inc. The lower-priority pulse is dropped, not queued.
- **Invalid captured value:** if the edited field is out of range (any digit > 9, hours > 23, minutes > 59), `Inc_btn` sets that field to 00.
- **Untouched fields:** fields not edited keep their captured value.
- `Field_sel` reflects the current state: 1/2/3 in SET_HR/SET_MIN/SET_SEC, 0 otherwise.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `Mode_btn` at edge t in RUN: SET_HR from t+1; the edit register holds `Time_cur` as sampled at t.
- `Inc_btn` at edge t: the updated field is visible on `Time_in` from t+1.
- `Mode_btn` at edge t in SET_SEC: `Set_time`=1 during cycle t+1 only; RUN from t+2.
- First `Sec_tick` after entering RUN (from reset or LOAD) is the TICK_DIV-th RUN cycle, so the loaded time is held a full second.
- TICK_DIV=1: `Sec_tick`=1 on every RUN cycle.
- Prescaler width is $clog2(TICK_DIV), minimum 1 bit. No overflow beyond TICK_DIV-1.

## Structure
- **Shared package `clock_ctrl_pkg`:**
  - State enum: RUN, SET_HR, SET_MIN, SET_SEC, LOAD.
  - `Field_sel` encodings.
  - BCD field bit-slice constants.
  - Field limits `HR_MAX`=8'h23, `MIN_MAX`=8'h59.
- **Sub-module `bcd2_inc`:** combinational two-digit BCD increment. Inputs: 8-bit value and 8-bit max. Output: the incremented value, wrapping max → 00 and mapping invalid → 00. Instantiated twice (hours, minutes).
- FSM, prescaler and edit register live in the top module.

## Test plan
Bench uses TICK_DIV=4.
- **Reset and tick:** release `Reset_n`, idle → `Sec_tick` high on RUN cycles 4, 8, 12; `Time_in`=0, `Set_time`=0 throughout.
- **Hour wrap:** `Time_cur`=0x225930, Mode, Inc ×2 → `Time_in`[23:16] goes 0x23 then 0x00; `Field_sel`=1.
- **Full set:**
  - Sequence: `Time_cur`=0x095959, Mode, Inc, Mode, Inc, Mode, Inc, Mode.
  - Required: single `Set_time` pulse with `Time_in`=0x100000; next `Sec_tick` 4 cycles after RUN re-entry.
- **Cancel:** SET_MIN then Cancel → RUN next cycle, no `Set_time`; `Sec_tick` resumes after 4 cycles.
- **Simultaneous:** Mode+Inc together in SET_HR at 0x08 → state SET_MIN, hours stay 0x08. Cancel+Mode together in SET_SEC → RUN, no load.
- **Reset mid-operation:** assert `Reset_n`=0 in the LOAD cycle or in SET_MIN → RUN, all outputs 0, no further `Set_time`. Invalid capture hours 0x2A + Inc → 0x00.
